word_piso: RTL and testbench

Parallel-in/serial-out reader for 32-bit register words. Accepts one full word over a valid/ready handshake, then emits it as WIDTH/SYM_W symbols on a second valid/ready stream with a last flag. It sits downstream of the 32-bit enable register and drains the stored word onto narrow links such as a byte bus or a debug port.

---
 rtl/word_piso_pkg.sv | 21 ++
 rtl/word_piso.sv | 89 ++++++++
 tb/tb_word_piso.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/word_piso_pkg.sv
// Shared types and sizing helpers for the word_piso parallel-in/serial-out reader.
package word_piso_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 32;
  localparam int SYM_W_DEF = 8;

  function automatic int calc_nsym(input int width, input int sym_w);
    return width / sym_w;
  endfunction

  // A single-symbol word still needs a one-bit counter to hold a legal value.
  function automatic int calc_cnt_w(input int width, input int sym_w);
    return (width / sym_w > 1) ? $clog2(width / sym_w) : 1;
  endfunction

endpackage

// File: rtl/word_piso.sv
// Serialises one WIDTH-bit word into WIDTH/SYM_W symbols with a last flag.
// Define WORD_PISO_MSB_FIRST_EN to emit the most-significant symbol first.
module word_piso
  import word_piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SYM_W = SYM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int NSYM  = calc_nsym(WIDTH, SYM_W);
  localparam int CNT_W = calc_cnt_w(WIDTH, SYM_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSYM - 1);

  generate
    if (WIDTH % SYM_W != 0) begin : g_bad_width
      $error("word_piso: WIDTH must be a multiple of SYM_W");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_shf;
  logic [CNT_W-1:0] cnt;
  logic [SYM_W-1:0] sym;
  logic             in_fire, out_fire;

`ifdef WORD_PISO_MSB_FIRST_EN
  assign sym      = sreg[WIDTH-1 -: SYM_W];
  assign sreg_shf = sreg << SYM_W;
`else
  assign sym      = sreg[SYM_W-1:0];
  assign sreg_shf = sreg >> SYM_W;
`endif

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (cnt == LAST_CNT);
        out_data  = sym;
        if (out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered state, shift register and symbol counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        sreg <= in_data;
        cnt  <= '0;
      end else if (out_fire) begin
        sreg <= sreg_shf;
        cnt  <= out_last ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_word_piso.sv
// Self-checking bench for word_piso: queue-based symbol model plus directed literal cases.
module tb_word_piso;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];   // symbols still to be emitted for the word in flight
  logic [8:0] got[$];  // {last, data} of every completed output handshake

  word_piso #(.WIDTH(32), .SYM_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_sym(input logic [31:0] w, input int k);
`ifdef WORD_PISO_MSB_FIRST_EN
    return w[31 - 8*k -: 8];
`else
    return w[8*k +: 8];
`endif
  endfunction

  // Model: a word is taken whenever nothing is pending; each accepted handshake pops one symbol.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else if (mq.size() == 0) begin
      if (in_valid)
        for (int k = 0; k < 4; k++) mq.push_back(model_sym(in_data, k));
    end else if (out_ready) begin
      void'(mq.pop_front());
    end
  end

  always @(posedge clk)
    if (rst && out_valid && out_ready) got.push_back({out_last, out_data});

  always @(negedge clk) begin
    chk("in_ready",  in_ready,  mq.size() == 0);
    chk("busy",      busy,      mq.size() != 0);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("out_last",  out_last,  mq.size() == 1);
    chk("out_data",  out_data,  (mq.size() != 0) ? mq[0] : 8'h00);
  end

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_accept_wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && !out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_wait", in_ready && !out_valid, 1'b1);
  endtask

  task automatic chk_got(input string name, input logic [8:0] exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_sym%0d", name, i), (i < got.size()) ? got[i] : 9'h1FF, exp[i]);
  endtask

  initial begin
    logic [8:0] e[$];
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;

    // Basic drain
    out_ready = 1'b1;
    got.delete();
    send_word(32'hABCDABCD);
    wait_idle();
`ifdef WORD_PISO_MSB_FIRST_EN
    e = '{9'h0AB, 9'h0CD, 9'h0AB, 9'h1CD};
`else
    e = '{9'h0CD, 9'h0AB, 9'h0CD, 9'h1AB};
`endif
    chk_got("basic", e);

    // Backpressure on symbol 1
    got.delete();
    send_word(32'h11223344);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
`ifdef WORD_PISO_MSB_FIRST_EN
      chk("stall_data", out_data, 8'h22);
`else
      chk("stall_data", out_data, 8'h33);
`endif
      chk("stall_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();
`ifdef WORD_PISO_MSB_FIRST_EN
    e = '{9'h011, 9'h022, 9'h033, 9'h144};
`else
    e = '{9'h044, 9'h033, 9'h022, 9'h111};
`endif
    chk_got("backpressure", e);

    // Word offered while serialising waits for the drain
    got.delete();
    send_word(32'h01234567);
    chk("blocked_in_ready", in_ready, 1'b0);
    send_word(32'hDEADBEEF);
    wait_idle();
`ifdef WORD_PISO_MSB_FIRST_EN
    e = '{9'h001, 9'h023, 9'h045, 9'h167, 9'h0DE, 9'h0AD, 9'h0BE, 9'h1EF};
`else
    e = '{9'h067, 9'h045, 9'h023, 9'h101, 9'h0EF, 9'h0BE, 9'h0AD, 9'h1DE};
`endif
    chk_got("blocked", e);

    // Asynchronous reset after two symbols
    got.delete();
    send_word(32'hCAFEF00D);
    @(posedge clk);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, 8'h00);
`ifdef WORD_PISO_MSB_FIRST_EN
    e = '{9'h0CA, 9'h0FE};
`else
    e = '{9'h00D, 9'h0F0};
`endif
    chk_got("pre_reset", e);
    got.delete();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    send_word(32'h00000001);
    wait_idle();
`ifdef WORD_PISO_MSB_FIRST_EN
    e = '{9'h000, 9'h000, 9'h000, 9'h101};
`else
    e = '{9'h001, 9'h000, 9'h000, 9'h100};
`endif
    chk_got("post_reset", e);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = $urandom_range(0, 1);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
